aud_i2s_rx: RTL and testbench
=============================

Name: aud_i2s_rx

Overview:
- Receive side of the WM8731 codec audio path; complement of the existing audio DAC transmitter.
- Codec is bus master: it drives AUD_BCLK and AUD_ADCLRCK. This block samples AUD_ADCDAT and deserialises I2S stereo frames into parallel left/right samples.
- Frames are buffered in a small FIFO with a valid/ready output, consumed by an Avalon-MM CSR wrapper that the HPS reads.

Parameters:
- DATA_W, 16, bits per channel word captured, MSB first.
- FIFO_DEPTH, 4, stereo frames buffered; power of two, minimum 2.

Ports:
- clk  input  1  system clock, 50 MHz; must be at least 8x BCLK.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  receiver enable; low forces IDLE.
- aud_bclk  input  1  codec bit clock, asynchronous to clk.
- aud_adclrck  input  1  codec ADC word select: 0 = left, 1 = right.
- aud_adcdat  input  1  codec ADC serial data.
- sample_valid  output  1  FIFO head frame available.
- sample_ready  input  1  consumer accepts head frame.
- sample_left  output  DATA_W  head frame, left channel.
- sample_right  output  DATA_W  head frame, right channel.
- overflow  output  1  sticky: a frame was dropped.
- clear_ovf  input  1  single-cycle pulse that clears overflow.

Behaviour:
- Reset values: sample_valid=0, sample_left=0, sample_right=0, overflow=0; FSM in IDLE; FIFO empty; all synchroniser flops 0.
- Synchronisation: bclk, lrck and adcdat each pass through 2 flops. A BCLK rise event is bclk_s1 & ~bclk_s2. All serial logic acts only on rise events.
- At each rise event, sample lrck_s and dat_s together and compare lrck_s with its value at the previous rise event. A difference is an LR edge.
- FSM states and transitions:
  - IDLE: wait for an LR edge to 0 (start of left). Then go to SKIP with chan=L. Any right word in progress is ignored, which aligns the block to frames.
  - SKIP: consume exactly one rise event (the I2S one-bit delay). Clear the shift register and bit count, then go to SHIFT.
  - SHIFT: shift dat_s into the LSB on each rise event and increment bit count.
    - At bit count == DATA_W: commit the word, go to WAIT.
    - An LR edge before DATA_W bits (short word): left-align the bits received, zero-fill the LSBs, commit, then go straight to SKIP for the new channel.
  - WAIT: ignore extra bits. On an LR edge, go to SKIP with chan = lrck_s.
- Commit rules:
  - Left commit latches the left holding register and sets left_ok.
  - Right commit with left_ok=1 pushes {left, right} into the FIFO and clears left_ok.
  - Right commit with left_ok=0 is discarded.
  - An LR edge to 0 while already in left (missed edge) restarts left and keeps left_ok unchanged.
- Latency: sample_valid rises 2 clk cycles after the rise event that carries the last right bit (one cycle commit, one cycle FIFO write).
- Output handshake:
  - A pop occurs when sample_valid && sample_ready.
  - sample_left and sample_right hold stable while valid && !ready.
  - sample_valid may not drop without a pop, except on reset.
- FIFO boundaries:
  - Push when full with no pop that cycle: frame dropped, overflow set. The FIFO retains the older frames.
  - Push and pop in the same cycle when full: push accepted, no overflow.
  - Push into empty: sample_valid rises the next cycle.
- overflow: if clear_ovf and a new overflow happen in the same cycle, set wins.
- en low: FSM returns to IDLE next cycle, the partial frame and left_ok are discarded, and the FIFO contents are kept and still poppable.
- Reset asserted mid-word: everything returns to reset values immediately. The first frame after release waits for a fresh LR edge to 0.
- Wrap-around: bit counter is $clog2(DATA_W+1) bits wide and saturates in WAIT. FIFO pointers are one bit wider than the address so full and empty are distinguished.

Optional Feature:
- Macro AUD_RX_PEAK_EN.
- Defined:
  - Adds output ports peak_left and peak_right, each DATA_W-1 bits, plus input peak_clear (1 bit).
  - On each pushed frame, compute the absolute value of each channel (two's complement). Saturate the most negative value to all ones.
  - Each peak register keeps the maximum absolute value seen.
  - peak_clear zeroes both registers; if a push coincides with peak_clear, the new frame's values are loaded.
  - Reset value 0.
- Undefined: these ports and all related logic are absent.

Decomposition:
- Package aud_pkg:
  - Parameter AUD_DATA_W = 16.
  - typedef aud_frame_t, packed struct {left, right}.
  - typedef enum rx_state_t {IDLE, SKIP, SHIFT, WAIT}.
  - typedef chan_t {CH_L, CH_R}.
- Sub-module aud_frame_fifo: synchronous FIFO of aud_frame_t with push/full/pop/empty and show-ahead output, parameterised by FIFO_DEPTH.

Test Plan:
- Serial I2S frame L=16'hA5C3, R=16'h0F0F at BCLK = clk/16, ready held 1 -> one beat, left=A5C3, right=0F0F, overflow=0.
- Five frames L=0001..0005 with ready=0 -> overflow=1 after the fifth. Then ready=1 pops L=0001..0004 in order, then valid=0.
- Left word of only 12 bits, 0xABC, then LR edge -> left=16'hABC0.
- Reset released while lrck=1 mid right word -> no output for that right word; first output is the next complete L/R pair.
- FIFO full with push and pop in the same cycle -> pushed frame retained, overflow stays 0. clear_ovf pulse after an overflow -> overflow=0.
- en dropped mid left word, then raised -> partial word discarded; next full frame is received correctly.

Source files
------------

// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared types for the WM8731 I2S ADC receive path
package aud_pkg;

   parameter int AUD_DATA_W = 16;

   typedef struct packed {
      logic [AUD_DATA_W-1:0] left;
      logic [AUD_DATA_W-1:0] right;
   } aud_frame_t;

   typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT} rx_state_t;

   typedef enum logic {CH_L = 1'b0, CH_R = 1'b1} chan_t;

endpackage

// File: rtl/aud_frame_fifo.sv
// rtl/aud_frame_fifo.sv - show-ahead synchronous FIFO of stereo frames
module aud_frame_fifo
   import aud_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type frame_t = aud_frame_t
) (
   input  logic   clk,
   input  logic   reset_n,
   input  logic   push,
   input  frame_t push_data,
   output logic   full,
   input  logic   pop,
   output frame_t pop_data,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);

   frame_t        mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          wr_en;
   logic          rd_en;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign wr_en    = push && (!full || pop);
   assign rd_en    = pop && !empty;
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/aud_i2s_rx.sv
// rtl/aud_i2s_rx.sv - I2S ADC deserialiser with frame FIFO; AUD_RX_PEAK_EN adds peak meters
module aud_i2s_rx
   import aud_pkg::*;
#(
   parameter int DATA_W     = AUD_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic              aud_bclk,
   input  logic              aud_adclrck,
   input  logic              aud_adcdat,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic [DATA_W-1:0] sample_left,
   output logic [DATA_W-1:0] sample_right,
   output logic              overflow,
`ifdef AUD_RX_PEAK_EN
   output logic [DATA_W-2:0] peak_left,
   output logic [DATA_W-2:0] peak_right,
   input  logic              peak_clear,
`endif
   input  logic              clear_ovf
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DATA_W);
   localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

   typedef struct packed {
      logic [DATA_W-1:0] left;
      logic [DATA_W-1:0] right;
   } frame_t;

   logic bclk_m, bclk_s1, bclk_s2;
   logic lrck_m, lrck_s, lrck_prev;
   logic dat_m, dat_s;
   logic rise, lr_edge;

   rx_state_t         state;
   chan_t             chan;
   logic [DATA_W-1:0] shift_reg;
   logic [CW-1:0]     bit_cnt;
   logic [DATA_W-1:0] left_hold;
   logic              left_ok;
   logic              push_req;
   frame_t            push_data;

   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] commit_word;
   logic              commit_fire;

   logic   fifo_full, fifo_empty, pop;
   frame_t head;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bclk_m  <= 1'b0;
         bclk_s1 <= 1'b0;
         bclk_s2 <= 1'b0;
         lrck_m  <= 1'b0;
         lrck_s  <= 1'b0;
         dat_m   <= 1'b0;
         dat_s   <= 1'b0;
      end else begin
         bclk_m  <= aud_bclk;
         bclk_s1 <= bclk_m;
         bclk_s2 <= bclk_s1;
         lrck_m  <= aud_adclrck;
         lrck_s  <= lrck_m;
         dat_m   <= aud_adcdat;
         dat_s   <= dat_m;
      end
   end

   assign rise    = bclk_s1 & ~bclk_s2;
   assign lr_edge = (lrck_s != lrck_prev);
   assign shifted = {shift_reg[DATA_W-2:0], dat_s};

   // A short word is cut by the LR edge and left-aligned; an edge back into
   // the channel already being received is a missed edge and commits nothing.
   always_comb begin
      commit_fire = 1'b0;
      commit_word = shifted;
      if (state == SHIFT) begin
         if (lr_edge) begin
            commit_fire = (chan_t'(lrck_s) != chan);
            commit_word = shift_reg << (FULL_CNT - bit_cnt);
         end else if (bit_cnt == LAST_CNT) begin
            commit_fire = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         chan      <= CH_L;
         shift_reg <= '0;
         bit_cnt   <= '0;
         lrck_prev <= 1'b0;
         left_hold <= '0;
         left_ok   <= 1'b0;
         push_req  <= 1'b0;
         push_data <= '0;
      end else begin
         push_req <= 1'b0;
         if (rise) lrck_prev <= lrck_s;
         if (!en) begin
            state     <= IDLE;
            left_ok   <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
         end else if (rise) begin
            if (commit_fire) begin
               if (chan == CH_L) begin
                  left_hold <= commit_word;
                  left_ok   <= 1'b1;
               end else if (left_ok) begin
                  push_req        <= 1'b1;
                  push_data.left  <= left_hold;
                  push_data.right <= commit_word;
                  left_ok         <= 1'b0;
               end
            end
            case (state)
               IDLE: begin
                  if (lr_edge && !lrck_s) begin
                     chan  <= CH_L;
                     state <= SKIP;
                  end
               end
               SKIP: begin
                  shift_reg <= '0;
                  bit_cnt   <= '0;
                  state     <= SHIFT;
               end
               SHIFT: begin
                  if (lr_edge) begin
                     chan  <= chan_t'(lrck_s);
                     state <= SKIP;
                  end else begin
                     shift_reg <= shifted;
                     bit_cnt   <= bit_cnt + CW'(1);
                     if (bit_cnt == LAST_CNT) state <= WAIT;
                  end
               end
               WAIT: begin
                  if (lr_edge) begin
                     chan  <= chan_t'(lrck_s);
                     state <= SKIP;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign pop = sample_valid && sample_ready;

   aud_frame_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .frame_t (frame_t)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push_req),
      .push_data (push_data),
      .full      (fifo_full),
      .pop       (pop),
      .pop_data  (head),
      .empty     (fifo_empty)
   );

   assign sample_valid = !fifo_empty;
   assign sample_left  = fifo_empty ? '0 : head.left;
   assign sample_right = fifo_empty ? '0 : head.right;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else if (push_req && fifo_full && !pop) begin
         overflow <= 1'b1;
      end else if (clear_ovf) begin
         overflow <= 1'b0;
      end
   end

`ifdef AUD_RX_PEAK_EN
   logic              push_acc;
   logic [DATA_W-2:0] abs_l, abs_r;

   function automatic logic [DATA_W-2:0] abs_sat(input logic [DATA_W-1:0] x);
      logic [DATA_W-1:0] neg;
      neg = -x;
      if (!x[DATA_W-1])          return x[DATA_W-2:0];
      else if (x[DATA_W-2:0] == '0) return '1;
      else                       return neg[DATA_W-2:0];
   endfunction

   assign push_acc = push_req && (!fifo_full || pop);
   assign abs_l    = abs_sat(push_data.left);
   assign abs_r    = abs_sat(push_data.right);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         peak_left  <= '0;
         peak_right <= '0;
      end else if (peak_clear) begin
         peak_left  <= push_acc ? abs_l : '0;
         peak_right <= push_acc ? abs_r : '0;
      end else if (push_acc) begin
         if (abs_l > peak_left)  peak_left  <= abs_l;
         if (abs_r > peak_right) peak_right <= abs_r;
      end
   end
`endif

endmodule

// File: tb/tb_aud_i2s_rx.sv
// tb/tb_aud_i2s_rx.sv - table and scoreboard bench for aud_i2s_rx
module tb_aud_i2s_rx;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        en;
   logic        aud_bclk;
   logic        aud_adclrck;
   logic        aud_adcdat;
   logic        sample_valid;
   logic        sample_ready;
   logic [15:0] sample_left;
   logic [15:0] sample_right;
   logic        overflow;
   logic        clear_ovf;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [15:0] l;
      logic [15:0] r;
   } fr_t;

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      int          lbits;
      logic [15:0] exp_l;
      logic [15:0] exp_r;
   } vec_t;

   fr_t  exp_q[$];
   vec_t vecs[6];

   aud_i2s_rx dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .en           (en),
      .aud_bclk     (aud_bclk),
      .aud_adclrck  (aud_adclrck),
      .aud_adcdat   (aud_adcdat),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_left  (sample_left),
      .sample_right (sample_right),
      .overflow     (overflow),
      .clear_ovf    (clear_ovf)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // one BCLK period of clk/16; optional one-cycle ready pulse timed to the FIFO write
   task automatic bclk_cycle(input logic lr, input logic d, input bit pulse);
      aud_bclk    = 1'b0;
      aud_adclrck = lr;
      aud_adcdat  = d;
      repeat (8) tick();
      aud_bclk = 1'b1;
      if (pulse) begin
         repeat (3) tick();
         sample_ready = 1'b1;
         tick();
         sample_ready = 1'b0;
         repeat (4) tick();
      end else begin
         repeat (8) tick();
      end
   endtask

   // slot: LR-edge rise, delay rise, then nbits MSB first, then zero padding
   task automatic send_word(input logic lr, input logic [15:0] word, input int nbits,
                            input int slot, input bit pulse_last);
      for (int r = 0; r < slot; r++) begin
         logic d;
         d = (r >= 2 && (r - 2) < nbits) ? word[17 - r] : 1'b0;
         bclk_cycle(lr, d, pulse_last && (r == nbits + 1));
      end
   endtask

   task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int lbits,
                             input bit pulse);
      send_word(1'b0, l, lbits, (lbits < 16) ? lbits + 2 : 20, 1'b0);
      send_word(1'b1, r, 16, 20, pulse);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 4000) begin
         tick();
         n++;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   always @(negedge clk) begin
      if (reset_n && sample_valid && sample_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pop_unexpected: got %h/%h expected no beat", sample_left, sample_right);
         end else begin
            fr_t f;
            f = exp_q.pop_front();
            check("pop_left", {16'h0, sample_left}, {16'h0, f.l});
            check("pop_right", {16'h0, sample_right}, {16'h0, f.r});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{16'hA5C3, 16'h0F0F, 16, 16'hA5C3, 16'h0F0F};
      vecs[1] = '{16'hABC0, 16'h1234, 12, 16'hABC0, 16'h1234};
      vecs[2] = '{16'h8000, 16'h7FFF, 16, 16'h8000, 16'h7FFF};
      vecs[3] = '{16'hFFFF, 16'h0000, 16, 16'hFFFF, 16'h0000};
      vecs[4] = '{16'h8000, 16'h8001,  1, 16'h8000, 16'h8001};
      vecs[5] = '{16'h5A00, 16'hC3C3,  8, 16'h5A00, 16'hC3C3};

      reset_n = 1'b0; en = 1'b1; aud_bclk = 1'b0; aud_adclrck = 1'b0; aud_adcdat = 1'b0;
      sample_ready = 1'b0; clear_ovf = 1'b0;
      repeat (4) tick();
      check("rst_valid", sample_valid, 0);
      check("rst_left", sample_left, 0);
      check("rst_right", sample_right, 0);
      check("rst_ovf", overflow, 0);
      reset_n = 1'b1;
      tick();

      // align: a right slot so the first left slot presents an LR edge to 0
      send_word(1'b1, 16'h0, 0, 4, 1'b0);
      sample_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back('{vecs[i].exp_l, vecs[i].exp_r});
         send_frame(vecs[i].l, vecs[i].r, vecs[i].lbits, 1'b0);
      end
      wait_drain("table_drain");
      check("table_ovf", overflow, 0);

      // overflow: five frames into a four-deep FIFO
      sample_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) exp_q.push_back('{16'(i), 16'(16'h0100 + i)});
         send_frame(16'(i), 16'(16'h0100 + i), 16, 1'b0);
      end
      check("ovf_set", overflow, 1);
      check("hold_left", sample_left, 16'h0001);
      repeat (5) tick();
      check("hold_right", sample_right, 16'h0101);
      sample_ready = 1'b1;
      wait_drain("ovf_drain");
      repeat (3) tick();
      check("ovf_empty_valid", sample_valid, 0);
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      tick();
      check("ovf_cleared", overflow, 0);

      // full FIFO: the fifth push coincides with a pop
      sample_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back('{16'(16'h2000 + i), 16'(16'h3000 + i)});
         send_frame(16'(16'h2000 + i), 16'(16'h3000 + i), 16, i == 4);
      end
      repeat (4) tick();
      check("full_pushpop_ovf", overflow, 0);
      check("full_pushpop_size", exp_q.size(), 4);
      sample_ready = 1'b1;
      wait_drain("full_drain");

      // en dropped mid left word: FIFO content kept, partial frame discarded
      sample_ready = 1'b0;
      exp_q.push_back('{16'hC0DE, 16'hBEEF});
      send_frame(16'hC0DE, 16'hBEEF, 16, 1'b0);
      send_word(1'b0, 16'hF000, 4, 6, 1'b0);
      en = 1'b0;
      repeat (4) tick();
      check("en_low_valid", sample_valid, 1);
      check("en_low_left", sample_left, 16'hC0DE);
      en = 1'b1;
      sample_ready = 1'b1;
      send_word(1'b0, 16'hFFFF, 14, 14, 1'b0);
      send_word(1'b1, 16'h5555, 16, 20, 1'b0);
      exp_q.push_back('{16'h1357, 16'h2468});
      send_frame(16'h1357, 16'h2468, 16, 1'b0);
      wait_drain("en_drain");

      // reset mid right word, released while lrck is high
      send_word(1'b0, 16'h1111, 16, 20, 1'b0);
      send_word(1'b1, 16'h9999, 6, 8, 1'b0);
      reset_n = 1'b0;
      repeat (3) tick();
      check("midrst_valid", sample_valid, 0);
      check("midrst_left", sample_left, 0);
      check("midrst_ovf", overflow, 0);
      reset_n = 1'b1;
      send_word(1'b1, 16'h9999, 10, 12, 1'b0);
      exp_q.push_back('{16'h2222, 16'h3333});
      send_frame(16'h2222, 16'h3333, 16, 1'b0);
      wait_drain("midrst_drain");
      repeat (3) tick();
      check("final_valid", sample_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
